// File: rtl/atconv_pkg.sv
`default_nettype none
// atconv_pkg: FSM states, fixed-point constants and the 3x3 tap offset table shared by atconv_engine.
// Rev 1.0
package atconv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV_RD   = 3'd1,
    CONV_LAST = 3'd2,
    CONV_WR   = 3'd3,
    POOL_RD   = 3'd4,
    POOL_LAST = 3'd5,
    POOL_WR   = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam int DW_DEF     = 13;
  localparam int FRAC_DEF   = 4;
  localparam int DW_MAX_DEF = (1 << (DW_DEF - 1)) - 1;

  // Weight code meaning "tap contributes nothing".
  localparam logic [2:0] ZERO_CODE = 3'd7;

  function automatic int dw_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Unit row/column multipliers for tap k (row-major 3x3 window).
  function automatic int tap_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return -1;
      4'd3, 4'd4, 4'd5: return 0;
      default:          return 1;
    endcase
  endfunction

  function automatic int tap_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return -1;
      4'd1, 4'd4, 4'd7: return 0;
      default:          return 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/atconv_tap_addr.sv
`default_nettype none
// atconv_tap_addr: image address of one dilated tap with replicate padding at the borders.
// Rev 1.0
module atconv_tap_addr
  import atconv_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int DIL_MAX = 4,
  parameter int RW      = $clog2(IMG_H),
  parameter int CW      = $clog2(IMG_W),
  parameter int DLW     = $clog2(DIL_MAX + 1)
) (
  input  logic [RW-1:0]    row,
  input  logic [CW-1:0]    col,
  input  logic [3:0]       tap,
  input  logic [DLW-1:0]   dil,
  output logic [RW+CW-1:0] addr
);

  int r_off;
  int c_off;

  always_comb begin
    r_off = int'(row) + tap_dy(tap) * int'(dil);
    c_off = int'(col) + tap_dx(tap) * int'(dil);
    if (r_off < 0)              r_off = 0;
    else if (r_off > IMG_H - 1) r_off = IMG_H - 1;
    if (c_off < 0)              c_off = 0;
    else if (c_off > IMG_W - 1) c_off = IMG_W - 1;
  end

  assign addr = {r_off[RW-1:0], c_off[CW-1:0]};

endmodule
`default_nettype wire

// File: rtl/atconv_engine.sv
`default_nettype none
// atconv_engine: 3x3 dilated conv + bias + saturating ReLU (layer 0), then optional 2x2 max-pool with ceil (layer 1).
// Rev 1.0
module atconv_engine
  import atconv_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int DW      = DW_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int ACC_W   = 17,
  parameter int DIL_MAX = 4,
  parameter int AW      = $clog2(IMG_W * IMG_H)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ready,
  output logic                             busy,
  input  logic [26:0]                      cfg_shift,
  input  logic [8:0]                       cfg_neg,
  input  logic signed [DW-1:0]             cfg_bias,
  input  logic [$clog2(DIL_MAX+1)-1:0]     cfg_dil,
  input  logic                             cfg_pool_en,
  input  logic                             cfg_ceil_en,
  output logic [AW-1:0]                    iaddr,
  input  logic signed [DW-1:0]             idata,
  output logic                             cwr,
  output logic [AW-1:0]                    caddr_wr,
  output logic [DW-1:0]                    cdata_wr,
  output logic                             crd,
  output logic [AW-1:0]                    caddr_rd,
  input  logic signed [DW-1:0]             cdata_rd,
  output logic                             csel
);

  localparam int DLW = $clog2(DIL_MAX + 1);
  localparam int CW  = $clog2(IMG_W);
  localparam int PW  = AW - 2;
  localparam logic signed [ACC_W:0] V_MAX = (ACC_W + 1)'(dw_max(DW));
  localparam logic [DW:0]           P_MAX = (DW + 1)'(dw_max(DW));

  state_t state, state_nx;

  logic [26:0]             shift_r;
  logic [8:0]              neg_r;
  logic signed [DW-1:0]    bias_r;
  logic [DLW-1:0]          dil_r;
  logic                    pool_r, ceil_r;
  logic [AW-1:0]           pix;
  logic [3:0]              tap;
  logic signed [ACC_W-1:0] acc;
  logic [PW-1:0]           pp;
  logic [2:0]              q;
  logic signed [DW-1:0]    mx;

  logic pix_last, pp_last;
  assign pix_last = &pix;
  assign pp_last  = &pp;

  logic [DLW-1:0] dil_in;
  always_comb begin
    if (cfg_dil == '0)                dil_in = DLW'(1);
    else if (cfg_dil > DLW'(DIL_MAX)) dil_in = DLW'(DIL_MAX);
    else                              dil_in = cfg_dil;
  end

  // iaddr is registered, so the address computed here is the one for the next cycle's tap.
  logic [AW-1:0]  a_pix, a_out;
  logic [3:0]     a_tap;
  logic [DLW-1:0] a_dil;
  always_comb begin
    a_pix = pix;
    a_tap = tap + 4'd1;
    a_dil = dil_r;
    if (state == IDLE) begin
      a_pix = '0;
      a_tap = '0;
      a_dil = dil_in;
    end else if (state == CONV_WR) begin
      a_pix = pix + AW'(1);
      a_tap = '0;
    end
  end

  atconv_tap_addr #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DIL_MAX(DIL_MAX)
  ) u_tap_addr (
    .row (a_pix[AW-1:CW]),
    .col (a_pix[CW-1:0]),
    .tap (a_tap),
    .dil (a_dil),
    .addr(a_out)
  );

  // Data for tap k-1 arrives while tap k is addressed.
  logic [3:0]              pi;
  logic [2:0]              code;
  logic signed [ACC_W-1:0] ext, shd, prod, acc_sum;
  logic signed [ACC_W:0]   v;
  logic [DW-1:0]           conv_q;
  assign pi      = tap - 4'd1;
  assign code    = 3'(shift_r >> (3 * pi));
  assign ext     = {{(ACC_W - DW){idata[DW-1]}}, idata};
  assign shd     = ext >>> code;
  assign prod    = (code == ZERO_CODE) ? '0 : (neg_r[pi] ? -shd : shd);
  assign acc_sum = acc + prod;
  assign v       = {acc_sum[ACC_W-1], acc_sum} + {{(ACC_W + 1 - DW){bias_r[DW-1]}}, bias_r};

  always_comb begin
    if (v < 0)          conv_q = '0;
    else if (v > V_MAX) conv_q = DW'(V_MAX);
    else                conv_q = v[DW-1:0];
  end

  logic signed [DW-1:0] mx_nx;
  logic [DW:0]          ceil_v;
  logic [DW-1:0]        pool_q;
  assign mx_nx = (cdata_rd > mx) ? cdata_rd : mx;

  always_comb begin
    ceil_v = {1'b0, mx_nx[DW-1:FRAC], {FRAC{1'b0}}} + (DW + 1)'(1 << FRAC);
    pool_q = mx_nx;
    if (ceil_r && (mx_nx[FRAC-1:0] != '0))
      pool_q = (ceil_v > P_MAX) ? DW'(P_MAX) : ceil_v[DW-1:0];
  end

  // Window address for pool pixel p, quadrant q: {r, q[1], c, q[0]} since W is a power of two.
  logic [PW-1:0] pa_p;
  logic [1:0]    pa_q;
  logic [AW-1:0] pool_addr;
  always_comb begin
    pa_p = pp;
    pa_q = 2'(q + 3'd1);
    if (state == CONV_WR) begin
      pa_p = '0;
      pa_q = '0;
    end else if (state == POOL_WR) begin
      pa_p = pp + PW'(1);
      pa_q = '0;
    end
  end
  assign pool_addr = {pa_p[PW-1:CW-1], pa_q[1], pa_p[CW-2:0], pa_q[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (ready) state_nx = CONV_RD;
      CONV_RD:   if (tap == 4'd8) state_nx = CONV_LAST;
      CONV_LAST: state_nx = CONV_WR;
      CONV_WR:   state_nx = pix_last ? (pool_r ? POOL_RD : DONE) : CONV_RD;
      POOL_RD:   if (q == 3'd3) state_nx = POOL_LAST;
      POOL_LAST: state_nx = POOL_WR;
      POOL_WR:   state_nx = pp_last ? DONE : POOL_RD;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 1'b0;
      iaddr    <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      shift_r  <= '0;
      neg_r    <= '0;
      bias_r   <= '0;
      dil_r    <= '0;
      pool_r   <= 1'b0;
      ceil_r   <= 1'b0;
      pix      <= '0;
      tap      <= '0;
      acc      <= '0;
      pp       <= '0;
      q        <= '0;
      mx       <= '0;
    end else begin
      busy <= (state_nx != IDLE) && (state_nx != DONE);
      cwr  <= 1'b0;
      csel <= 1'b0;
      case (state)
        IDLE: if (ready) begin
          shift_r <= cfg_shift;
          neg_r   <= cfg_neg;
          bias_r  <= cfg_bias;
          dil_r   <= dil_in;
          pool_r  <= cfg_pool_en;
          ceil_r  <= cfg_ceil_en;
          iaddr   <= a_out;
          pix     <= '0;
          tap     <= '0;
          acc     <= '0;
        end
        CONV_RD: begin
          tap <= tap + 4'd1;
          if (tap != 4'd0) acc <= acc_sum;
          if (tap != 4'd8) iaddr <= a_out;
        end
        CONV_LAST: begin
          acc      <= acc_sum;
          cwr      <= 1'b1;
          caddr_wr <= pix;
          cdata_wr <= conv_q;
        end
        CONV_WR: begin
          acc   <= '0;
          tap   <= '0;
          pix   <= pix + AW'(1);
          iaddr <= a_out;
          if (pix_last && pool_r) begin
            crd      <= 1'b1;
            caddr_rd <= pool_addr;
            q        <= '0;
            pp       <= '0;
            mx       <= '0;
          end
        end
        POOL_RD: begin
          q <= q + 3'd1;
          if (q != 3'd0) mx <= mx_nx;
          if (q == 3'd3) crd <= 1'b0;
          else           caddr_rd <= pool_addr;
        end
        POOL_LAST: begin
          mx       <= mx_nx;
          cwr      <= 1'b1;
          csel     <= 1'b1;
          caddr_wr <= AW'(pp);
          cdata_wr <= pool_q;
        end
        POOL_WR: begin
          mx <= '0;
          q  <= '0;
          pp <= pp + PW'(1);
          if (!pp_last) begin
            crd      <= 1'b1;
            caddr_rd <= pool_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atconv_engine.sv
`default_nettype none
// tb_atconv_engine: scoreboard bench for atconv_engine on a 16x16 image with behavioural golden model.
// Rev 1.0
module tb_atconv_engine;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int N  = W * H;
  localparam int AW = 8;
  localparam int DW = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready = 1'b0;
  logic busy;
  logic [26:0] cfg_shift = '0;
  logic [8:0]  cfg_neg = '0;
  logic signed [DW-1:0] cfg_bias = '0;
  logic [2:0]  cfg_dil = '0;
  logic cfg_pool_en = 1'b0;
  logic cfg_ceil_en = 1'b0;
  logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
  logic signed [DW-1:0] idata, cdata_rd;
  logic [DW-1:0] cdata_wr;
  logic cwr, crd, csel;

  logic signed [DW-1:0] img [N];
  logic [DW-1:0] l0 [N];
  logic [DW-1:0] l1 [N/4];

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];
  int wr_count = 0;
  bit sel1_seen = 1'b0;

  int k_shift [9];
  int k_neg [9];
  int bias, dil, pool_en, ceil_en;

  always #5 clk = ~clk;

  atconv_engine #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .cfg_shift(cfg_shift), .cfg_neg(cfg_neg), .cfg_bias(cfg_bias), .cfg_dil(cfg_dil),
    .cfg_pool_en(cfg_pool_en), .cfg_ceil_en(cfg_ceil_en),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  // Image ROM and result memories, one-cycle read latency.
  always @(posedge clk) begin
    idata    <= img[iaddr];
    cdata_rd <= l0[caddr_rd];
    if (cwr) begin
      if (csel) l1[caddr_wr[AW-3:0]] <= cdata_wr;
      else      l0[caddr_wr] <= cdata_wr;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_wr(input logic sel, input logic [7:0] a, input logic [12:0] d);
    return {sel, 7'd0, a, 3'd0, d};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (csel) sel1_seen = 1'b1;
      if (cwr) begin
        wr_count++;
        if (sb.size() == 0) check_value("sb_underflow", 32'(sb.size()), 32'd1);
        else check_value("wr", pack_wr(csel, caddr_wr, cdata_wr), sb.pop_front());
      end
    end
  end

  task automatic model_push();
    int d, acc, x, p, v, m, rr, cc;
    int e0 [N];
    d = (dil == 0) ? 1 : (dil > 4) ? 4 : dil;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          rr = r + (k / 3 - 1) * d;
          cc = c + (k % 3 - 1) * d;
          if (rr < 0) rr = 0;
          if (rr > H - 1) rr = H - 1;
          if (cc < 0) cc = 0;
          if (cc > W - 1) cc = W - 1;
          x = img[rr * W + cc];
          if (k_shift[k] != 7) begin
            p = x >>> k_shift[k];
            acc += (k_neg[k] != 0) ? -p : p;
          end
        end
        v = acc + bias;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        e0[r * W + c] = v;
        sb.push_back(pack_wr(1'b0, 8'(r * W + c), 13'(v)));
      end
    end
    if (pool_en != 0) begin
      for (int r = 0; r < H / 2; r++) begin
        for (int c = 0; c < W / 2; c++) begin
          m = 0;
          for (int j = 0; j < 4; j++) begin
            x = e0[(2 * r + j / 2) * W + 2 * c + j % 2];
            if (x > m) m = x;
          end
          if (ceil_en != 0 && (m % 16) != 0) begin
            m = m - (m % 16) + 16;
            if (m > 4095) m = 4095;
          end
          sb.push_back(pack_wr(1'b1, 8'(r * (W / 2) + c), 13'(m)));
        end
      end
    end
  endtask

  task automatic start_run();
    for (int k = 0; k < 9; k++) begin
      cfg_shift[3 * k +: 3] = 3'(k_shift[k]);
      cfg_neg[k] = (k_neg[k] != 0);
    end
    cfg_bias    = DW'(bias);
    cfg_dil     = 3'(dil);
    cfg_pool_en = (pool_en != 0);
    cfg_ceil_en = (ceil_en != 0);
    model_push();
    wr_count  = 0;
    sel1_seen = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic run_check(input string tag);
    int cnt, exp_len;
    start_run();
    check_value({tag, "_busy_rise"}, 32'(busy), 32'd1);
    cnt = 0;
    while (busy && cnt < 20000) begin
      cnt++;
      @(negedge clk);
    end
    exp_len = 11 * N + ((pool_en != 0) ? 6 * (N / 4) : 0);
    check_value({tag, "_busy_len"}, 32'(cnt), 32'(exp_len));
    check_value({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_ctrl"}, {28'd0, busy, cwr, crd, csel}, 32'd0);
    check_value({tag, "_addr"}, {8'd0, iaddr, caddr_wr, caddr_rd}, 32'd0);
    check_value({tag, "_data"}, {19'd0, cdata_wr}, 32'd0);
  endtask

  task automatic set_default_kernel();
    k_shift = '{4, 3, 4, 2, 0, 2, 4, 3, 4};
    k_neg   = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
  endtask

  task automatic set_single_tap(input int t);
    for (int k = 0; k < 9; k++) begin
      k_shift[k] = (k == t) ? 0 : 7;
      k_neg[k]   = 0;
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) img[i] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;

    set_default_kernel();
    bias = -12; dil = 2; pool_en = 1; ceil_en = 0;
    for (int i = 0; i < N; i++) img[i] = 13'sd16;
    run_check("uniform");
    check_value("uniform_l0", 32'(l0[37]), 32'd0);
    check_value("uniform_l1", 32'(l1[7]), 32'd0);

    bias = 0;
    for (int i = 0; i < N; i++) img[i] = '0;
    img[10 * W + 10] = 13'sd160;
    run_check("impulse");
    check_value("impulse_l0", 32'(l0[170]), 32'd160);
    check_value("impulse_l1", 32'(l1[45]), 32'd160);

    set_single_tap(4);
    bias = 0; dil = 1; ceil_en = 1;
    for (int i = 0; i < N; i++) img[i] = '0;
    img[0] = 13'sh015;
    img[2] = 13'shFF5;
    run_check("ceil_on");
    check_value("ceil_on_frac", 32'(l1[0]), 32'h020);
    check_value("ceil_on_sat", 32'(l1[1]), 32'hFFF);
    ceil_en = 0;
    run_check("ceil_off");
    check_value("ceil_off_frac", 32'(l1[0]), 32'h015);
    check_value("ceil_off_hi", 32'(l1[1]), 32'hFF5);

    for (int k = 0; k < 9; k++) begin k_shift[k] = 0; k_neg[k] = 0; end
    for (int i = 0; i < N; i++) img[i] = 13'sh0FFF;
    run_check("satur");
    check_value("satur_first", 32'(l0[0]), 32'hFFF);
    check_value("satur_last", 32'(l0[N-1]), 32'hFFF);

    for (int k = 0; k < 9; k++) begin
      k_shift[k] = int'($urandom_range(0, 7));
      k_neg[k]   = int'($urandom_range(0, 1));
    end
    for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(0, 8191));
    bias = int'($urandom_range(0, 400)) - 200;
    dil = 7; ceil_en = 1;
    run_check("rand_dil7");
    dil = 0; ceil_en = 0;
    run_check("rand_dil0");

    set_default_kernel();
    bias = 0; dil = 2; pool_en = 1; ceil_en = 0;
    for (int i = 0; i < N; i++) img[i] = '0;
    img[10 * W + 10] = 13'sd160;
    start_run();
    cnt = 0;
    while (wr_count < 100 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check_value("midrst_reach", {31'd0, wr_count >= 100}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_outputs_zero("midrst");
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    run_check("rerun");
    check_value("rerun_l0", 32'(l0[170]), 32'd160);

    set_single_tap(0);
    bias = 0; dil = 2; pool_en = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r * W + c] = DW'(r * 4 + c);
    run_check("bypass");
    check_value("clamp_1_1", 32'(l0[1 * W + 1]), 32'd0);
    check_value("clamp_5_7", 32'(l0[5 * W + 7]), 32'd17);
    check_value("bypass_writes", 32'(wr_count), 32'(N));
    check_value("bypass_csel", {31'd0, sel1_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
